clk_div_sched: RTL

//  Programmable clock-divider controller. Produces a divided clock clk_o and a
//  one-cycle tick_o at each clk_o rising edge. Sequences start/stop and accepts

---
 rtl/clk_div_sched.sv | 105 ++++++++++
 1 files changed

// File: rtl/clk_div_sched.sv
// rtl/clk_div_sched.sv - programmable clock divider with boundary-aligned ratio changes
module clk_div_sched #(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             clk_o,
  output logic             tick_o,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  localparam logic [DIV_W-1:0] DEF = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  state_t           state, state_nx;
  logic [DIV_W-1:0] cnt, cnt_nx, cnt_inc;
  logic [DIV_W-1:0] cur_div_nx, pend_div, pend_div_nx;
  logic [DIV_W-1:0] cfg_clamped, half, new_div;
  logic             clk_nx, tick_nx, accept, boundary;

  assign cfg_ready   = (state != PEND);
  assign busy        = (state != IDLE);
  assign accept      = cfg_valid & cfg_ready;
  assign cfg_clamped = (cfg_div < TWO) ? TWO : cfg_div;
  assign half        = cur_div >> 1;
  assign cnt_inc     = cnt + ONE;
  assign boundary    = (state != IDLE) && (cnt == cur_div - ONE);
  assign new_div     = (state == PEND) ? pend_div : cur_div;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    cur_div_nx  = cur_div;
    pend_div_nx = pend_div;
    clk_nx      = clk_o;
    tick_nx     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        clk_nx = 1'b0;
        if (accept) cur_div_nx = cfg_clamped;
        if (en) begin
          state_nx = RUN;
          clk_nx   = 1'b1;
          tick_nx  = 1'b1;
        end
      end
      default: begin
        if (boundary) begin
          // Pending ratio lands here even when stopping, so the next start uses it.
          cur_div_nx = new_div;
          cnt_nx     = '0;
          if (!en) begin
            state_nx = IDLE;
            clk_nx   = 1'b0;
            if (accept) cur_div_nx = cfg_clamped;
          end else begin
            state_nx = RUN;
            clk_nx   = 1'b1;
            tick_nx  = 1'b1;
            if (accept) begin
              pend_div_nx = cfg_clamped;
              state_nx    = PEND;
            end
          end
        end else begin
          cnt_nx = cnt_inc;
          clk_nx = (cnt_inc < half);
          if (accept) begin
            pend_div_nx = cfg_clamped;
            state_nx    = PEND;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_div  <= DEF;
      pend_div <= '0;
      clk_o    <= 1'b0;
      tick_o   <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      cur_div  <= cur_div_nx;
      pend_div <= pend_div_nx;
      clk_o    <= clk_nx;
      tick_o   <= tick_nx;
    end
  end

endmodule
